// File: rtl/bit_stat_pkg.sv
// Shared definitions for the bit statistics sequencer:
// mode codes, FSM state encoding and the BCD digit adjust helper.
package bit_stat_pkg;

   localparam logic [1:0] MODE_COUNT = 2'b00;
   localparam logic [1:0] MODE_EDGE  = 2'b01;
   localparam logic [1:0] MODE_RUN1  = 2'b10;
   localparam logic [1:0] MODE_RUN0  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_CONV = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Add 3 to every BCD digit that is 5 or more (double-dabble step).
   function automatic logic [11:0] bcd_adj(input logic [11:0] v);
      logic [11:0] r;
      r = v;
      for (int i = 0; i < 3; i++) begin
         if (r[i*4 +: 4] >= 4'd5) begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary to 3-digit BCD converter.
// load captures bin; CNT_W shift-add-3 steps follow, one per clock.
module bin2bcd_seq
   import bit_stat_pkg::*;
#(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] bin,
   output logic [11:0]      bcd
);

   logic [CNT_W-1:0] sh;
   logic [3:0]       left;
   logic [11:0]      adj;

   assign adj = bcd_adj(bcd);

   // Load operand, then shift one binary bit into the BCD field per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         bcd  <= '0;
         sh   <= '0;
         left <= '0;
      end else if (load) begin
         bcd  <= '0;
         sh   <= bin;
         left <= 4'(CNT_W);
      end else if (left != 4'd0) begin
         bcd  <= {adj[10:0], sh[CNT_W-1]};
         sh   <= sh << 1;
         left <= left - 4'd1;
      end
   end

endmodule

// File: rtl/bit_stat_seq.sv
// Serial bit statistics engine: scans an operand MSB first,
// then converts both results to BCD and presents them with done.
module bit_stat_seq
   import bit_stat_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] operand,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] result_a,
   output logic [CNT_W-1:0] result_b,
   output logic [3:0]       d1,
   output logic [3:0]       d2,
   output logic [3:0]       d3,
   output logic [3:0]       d4,
   output logic [3:0]       d5,
   output logic [3:0]       d6
);

   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CNT_W);

   state_t           state_q;
   state_t           state_n;
   logic [1:0]       mode_q;
   logic [WIDTH-1:0] opnd_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] a_q;
   logic [CNT_W-1:0] b_q;
   logic [CNT_W-1:0] run_q;
   logic             flag_q;
   logic [CNT_W-1:0] a_n;
   logic [CNT_W-1:0] b_n;
   logic [CNT_W-1:0] run_n;
   logic             flag_n;
   logic             accept;
   logic             scan_en;
   logic             scan_last;
   logic             conv_en;
   logic             conv_last;
   logic             bit_v;
   logic             hit;
   logic [11:0]      bcd_a;
   logic [11:0]      bcd_b;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_n;
      end
   end

   // Next-state logic: SCAN for WIDTH bits, CONV until BCD is settled.
   always_comb begin
      state_n = state_q;
      unique case (state_q)
         ST_IDLE: if (accept)    state_n = ST_SCAN;
         ST_SCAN: if (scan_last) state_n = ST_CONV;
         ST_CONV: if (conv_last) state_n = ST_DONE;
         ST_DONE:                state_n = ST_IDLE;
      endcase
   end

   // Control decode of the current state.
   always_comb begin
      accept    = 1'b0;
      scan_en   = 1'b0;
      scan_last = 1'b0;
      conv_en   = 1'b0;
      conv_last = 1'b0;
      unique case (state_q)
         ST_IDLE: accept = start;
         ST_SCAN: begin
            scan_en   = 1'b1;
            scan_last = (cnt_q == LAST_BIT);
         end
         ST_CONV: begin
            conv_en   = 1'b1;
            conv_last = (cnt_q == CONV_LAST);
         end
         ST_DONE: begin
         end
      endcase
   end

   // Per-bit statistic update for the bit currently at the MSB.
   always_comb begin
      bit_v  = opnd_q[WIDTH-1];
      hit    = (bit_v == (mode_q == MODE_RUN1));
      a_n    = a_q;
      b_n    = b_q;
      run_n  = run_q;
      flag_n = flag_q;
      case (mode_q)
         MODE_COUNT: begin
            if (bit_v) a_n = a_q + ONE;
            else       b_n = b_q + ONE;
         end
         MODE_EDGE: begin
            if (!bit_v && !flag_q) a_n = a_q + ONE;
            if (bit_v) flag_n = 1'b1;
            b_n = bit_v ? '0 : b_q + ONE;
         end
         default: begin
            run_n = hit ? run_q + ONE : '0;
            if (run_n > a_q) a_n = run_n;
            if (hit && !flag_q) b_n = b_q + ONE;
            flag_n = hit;
         end
      endcase
   end

   // Capture request, step the scan, count conversion cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q <= MODE_COUNT;
         opnd_q <= '0;
         cnt_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         run_q  <= '0;
         flag_q <= 1'b0;
      end else if (accept) begin
         mode_q <= mode;
         opnd_q <= operand;
         cnt_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         run_q  <= '0;
         flag_q <= 1'b0;
      end else if (scan_en) begin
         opnd_q <= opnd_q << 1;
         cnt_q  <= scan_last ? '0 : cnt_q + ONE;
         a_q    <= a_n;
         b_q    <= b_n;
         run_q  <= run_n;
         flag_q <= flag_n;
      end else if (conv_en) begin
         cnt_q <= cnt_q + ONE;
      end
   end

   // Converters load the final counts on the last scan edge.
   bin2bcd_seq #(.CNT_W(CNT_W)) u_bcd_a (
      .clk  (clk),
      .rst  (rst),
      .load (scan_last),
      .bin  (a_n),
      .bcd  (bcd_a)
   );

   bin2bcd_seq #(.CNT_W(CNT_W)) u_bcd_b (
      .clk  (clk),
      .rst  (rst),
      .load (scan_last),
      .bin  (b_n),
      .bcd  (bcd_b)
   );

   // Registered outputs, refreshed only when entering DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         result_a <= '0;
         result_b <= '0;
         d1       <= '0;
         d2       <= '0;
         d3       <= '0;
         d4       <= '0;
         d5       <= '0;
         d6       <= '0;
      end else begin
         busy <= (state_n != ST_IDLE);
         done <= (state_n == ST_DONE);
         if (conv_last) begin
            result_a <= a_q;
            result_b <= b_q;
            d1       <= bcd_a[11:8];
            d2       <= bcd_a[7:4];
            d3       <= bcd_a[3:0];
            d4       <= bcd_b[11:8];
            d5       <= bcd_b[7:4];
            d6       <= bcd_b[3:0];
         end
      end
   end

endmodule
